// File: rtl/bcd_subtractor_seq.sv
// Digit-serial packed-BCD subtractor (a - b), one digit per clock, LS digit first.
// Optional BCD_SUB_MAGNITUDE_EN: negate a negative result so diff = |a-b|.
module bcd_subtractor_seq #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                ready,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                borrow,
  output logic                err
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

`ifdef BCD_SUB_MAGNITUDE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, NEG = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, b_q;
  logic [IDX_W-1:0] idx_q;
  logic             br_q;
  logic             accept;
  logic             last;
  logic             bad_digit;
  logic [3:0]       dig_m, dig_s, dig_res;
  logic [5:0]       t;
  logic             br_n;

  // Any non-decimal nibble in either operand flags the operation as invalid
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Shared per-digit subtract with decimal borrow correction
  always_comb begin
    last  = (idx_q == LAST_IDX);
    dig_m = a_q[{idx_q, 2'b00} +: 4];
    dig_s = b_q[{idx_q, 2'b00} +: 4];
`ifdef BCD_SUB_MAGNITUDE_EN
    if (state_q == NEG) begin
      dig_m = 4'd0;
      dig_s = diff[{idx_q, 2'b00} +: 4];
    end
`endif
    t       = {2'b00, dig_m} - {2'b00, dig_s} - 6'(br_q);
    br_n    = t[5];
    dig_res = t[5] ? 4'(t + 6'd10) : t[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && ready) begin
          accept  = 1'b1;
          state_d = SUB;
        end
      end
      SUB: begin
        if (last) begin
`ifdef BCD_SUB_MAGNITUDE_EN
          state_d = (br_n && !err) ? NEG : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef BCD_SUB_MAGNITUDE_EN
      NEG: begin
        if (last) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs; ready only returns after a full idle cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      idx_q  <= '0;
      br_q   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      err    <= 1'b0;
      ready  <= 1'b1;
      done   <= 1'b0;
    end else begin
      done  <= (state_q == DONE);
      ready <= (state_q == IDLE) && (state_d == IDLE);
      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        diff   <= '0;
        borrow <= 1'b0;
        err    <= bad_digit;
        br_q   <= 1'b0;
        idx_q  <= '0;
      end else if (state_q == SUB) begin
        if (!err) diff[{idx_q, 2'b00} +: 4] <= dig_res;
        idx_q <= last ? '0 : idx_q + 1'b1;
        br_q  <= last ? 1'b0 : br_n;
        if (last) borrow <= br_n & ~err;
      end
`ifdef BCD_SUB_MAGNITUDE_EN
      else if (state_q == NEG) begin
        diff[{idx_q, 2'b00} +: 4] <= dig_res;
        idx_q <= last ? '0 : idx_q + 1'b1;
        br_q  <= last ? 1'b0 : br_n;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Self-checking bench for bcd_subtractor_seq (DIGITS=4), decimal reference model.
// Honours BCD_SUB_MAGNITUDE_EN to pick the expected result form and latency.
module tb_bcd_subtractor_seq;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         ready, done, borrow, err;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  bcd_subtractor_seq #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .diff(diff), .borrow(borrow), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
    logic         exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Decimal reference: plain integer subtraction, then format per configuration
  task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                           output logic [W-1:0] d, output logic br,
                           output logic er, output int lat);
    int pow = 1;
    int dv;
    for (int i = 0; i < DIGITS; i++) pow = pow * 10;
    er = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (ra[4*i +: 4] > 4'd9 || rb[4*i +: 4] > 4'd9) er = 1'b1;
    lat = DIGITS + 1;
    if (er) begin
      d  = '0;
      br = 1'b0;
    end else begin
      dv = bcd_to_int(ra) - bcd_to_int(rb);
      br = (dv < 0);
`ifdef BCD_SUB_MAGNITUDE_EN
      d = int_to_bcd(br ? -dv : dv);
      if (br) lat = 2 * DIGITS + 1;
`else
      d = int_to_bcd(br ? dv + pow : dv);
`endif
    end
  endtask

  // One operation: start, scramble operands, wait for done, check timing and results
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int inject,
                        input string tag);
    logic [W-1:0] ed;
    logic         eb, ee;
    int           lat, got, n, ready_bad, both_high;
    ref_model(ta, tb_, ed, eb, ee, lat);
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_idle"}, 32'(ready), 32'd1);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    check({tag, "_ready_fall"}, 32'(ready), 32'd0);
    got = 0; ready_bad = 0; both_high = 0;
    for (int k = 1; k <= 40 && got == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready && done) both_high++;
      if (ready) ready_bad++;
      if (done) got = k;
      if (k == inject) begin
        start = 1'b1; a = 16'h9999; b = 16'h0000;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(got), 32'(lat));
    check({tag, "_ready_low"}, 32'(ready_bad), 32'd0);
    check({tag, "_ready_done"}, 32'(both_high), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow), 32'(eb));
    check({tag, "_err"}, 32'(err), 32'(ee));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_ready_back"}, 32'(ready), 32'd1);
    check({tag, "_diff_hold"}, 32'(diff), 32'(ed));
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] ra, rb;
    int           done_seen;

    vecs[0] = '{16'h4321, 16'h1234, 16'h3087, 1'b0, 1'b0};
    vecs[1] = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0};
    vecs[3] = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1};
    vecs[4] = '{16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0};
`ifdef BCD_SUB_MAGNITUDE_EN
    vecs[2] = '{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0};
`else
    vecs[2] = '{16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h9999, 16'h0001, 1'b1, 1'b0};
`endif

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_borrow", 32'(borrow), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Hand-written constants must agree with the decimal model
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].va, vecs[i].vb, 0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tdiff", i), 32'(diff), 32'(vecs[i].exp_diff));
      check($sformatf("vec%0d_tborrow", i), 32'(borrow), 32'(vecs[i].exp_borrow));
      check($sformatf("vec%0d_terr", i), 32'(err), 32'(vecs[i].exp_err));
    end

    // start pulsed mid-operation is ignored
    run_op(16'h4321, 16'h1234, 2, "ignore_start");
    check("ignore_start_val", 32'(diff), 32'h3087);

    // Reset mid-operation aborts with no done pulse
    @(negedge clk);
    a = 16'h4321; b = 16'h1234; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_op(16'h1000, 16'h0001, 0, "after_abort");

    // Randomized operations against the reference model
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 15) == 0) rb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      run_op(ra, rb, 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
